c432_key_loader: RTL and testbench



---
 rtl/c432_key_loader.sv | 163 ++++++++++++++++
 tb/tb_c432_key_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 core: fetches the key from NVM over a req/ack handshake and applies it once accepted.
// Optional even-parity check over the fetched key is enabled by defining C432_KEY_PARITY_EN.
module c432_key_loader #(
  parameter int unsigned KEY_WIDTH = 2,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 nvm_req,
  input  logic                 nvm_ack,
  input  logic                 nvm_bit,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 key_valid,
  output logic                 key_err,
  output logic                 busy
);

`ifdef C432_KEY_PARITY_EN
  localparam int unsigned NB = KEY_WIDTH + 1;
`else
  localparam int unsigned NB = KEY_WIDTH;
`endif
  localparam int unsigned CW = $clog2(KEY_WIDTH + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    GAP   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  logic [NB-1:0]   shift_q;
  logic [NB-1:0]   shift_d;
  logic [CW-1:0]   bit_cnt_q;
  logic [TW-1:0]   tmo_q;
  logic            tmo_hit;
  logic            check_pass;

  logic                 nvm_req_d;
  logic                 busy_d;
  logic                 key_valid_d;
  logic                 key_err_d;
  logic [KEY_WIDTH-1:0] key_d;

  assign shift_d = shift_q | (NB'(nvm_bit) << bit_cnt_q);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT));

`ifdef C432_KEY_PARITY_EN
  // Key bits plus the even-parity bit must XOR to zero.
  assign check_pass = ~(^shift_q);
`else
  assign check_pass = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = REQ;
      end
      REQ: begin
        if (nvm_ack)      state_nxt = GAP;
        else if (tmo_hit) state_nxt = ERR;
      end
      GAP: begin
        state_nxt = (bit_cnt_q == CW'(NB)) ? CHECK : REQ;
      end
      CHECK: begin
        state_nxt = check_pass ? DONE : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    nvm_req_d   = 1'b0;
    busy_d      = 1'b0;
    key_valid_d = 1'b0;
    key_err_d   = 1'b0;
    key_d       = '0;
    case (state_nxt)
      REQ: begin
        nvm_req_d = 1'b1;
        busy_d    = 1'b1;
      end
      GAP, CHECK: busy_d = 1'b1;
      DONE: begin
        key_valid_d = 1'b1;
        key_d       = shift_q[KEY_WIDTH-1:0];
      end
      ERR:     key_err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nvm_req   <= 1'b0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      key       <= '0;
    end else begin
      nvm_req   <= nvm_req_d;
      busy      <= busy_d;
      key_valid <= key_valid_d;
      key_err   <= key_err_d;
      key       <= key_d;
    end
  end

  // Shift register, bit counter and saturating timeout counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
          end
        end
        REQ: begin
          if (nvm_ack) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CW'(1);
            tmo_q     <= '0;
          end else if (tmo_hit) begin
            shift_q <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        CHECK: begin
          if (!check_pass) shift_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed self-checking bench for c432_key_loader (KEY_WIDTH=2, TIMEOUT=15).
// Follows C432_KEY_PARITY_EN the same way as the design.
module tb_c432_key_loader;

`ifdef C432_KEY_PARITY_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       nvm_req;
  logic       nvm_ack;
  logic       nvm_bit;
  logic [1:0] key;
  logic       key_valid;
  logic       key_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  c432_key_loader #(.KEY_WIDTH(2), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nvm_req   (nvm_req),
    .nvm_ack   (nvm_ack),
    .nvm_bit   (nvm_bit),
    .key       (key),
    .key_valid (key_valid),
    .key_err   (key_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial stream for key k: key bits LSB first, then even parity (optionally corrupted)
  function automatic logic [2:0] enc(input logic [1:0] k, input logic flip);
    return {(^k) ^ flip, k};
  endfunction

  // Zero-wait NVM load; start must be sampled in IDLE/DONE/ERR
  task automatic run_load(input logic [2:0] bits, input bit inject, input logic [1:0] exp_key,
                          input bit exp_ok, input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " req_rise"}, 32'(nvm_req), 32'd1);
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    check({tag, " key_cleared"}, 32'(key), 32'd0);
    check({tag, " valid_cleared"}, 32'(key_valid), 32'd0);
    for (int i = 0; i < NB; i++) begin
      nvm_bit = bits[i];
      nvm_ack = 1'b1;
      if (inject && i == 1) start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " gap_req_low"}, 32'(nvm_req), 32'd0);
      check({tag, " gap_busy"}, 32'(busy), 32'd1);
      step();
    end
    nvm_ack = 1'b0;
    nvm_bit = 1'b0;
    check({tag, " check_no_req"}, 32'(nvm_req), 32'd0);
    check({tag, " check_not_valid"}, 32'(key_valid), 32'd0);
    check({tag, " check_busy"}, 32'(busy), 32'd1);
    step();
    check({tag, " valid"}, 32'(key_valid), 32'(exp_ok));
    check({tag, " err"}, 32'(key_err), 32'(!exp_ok));
    check({tag, " key"}, 32'(key), exp_ok ? 32'(exp_key) : 32'd0);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " req_end"}, 32'(nvm_req), 32'd0);
    step();
    check({tag, " key_hold"}, 32'(key), exp_ok ? 32'(exp_key) : 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    nvm_ack = 1'b0;
    nvm_bit = 1'b0;
    step();
    step();
    check("rst req", 32'(nvm_req), 32'd0);
    check("rst key", 32'(key), 32'd0);
    check("rst valid", 32'(key_valid), 32'd0);
    check("rst err", 32'(key_err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle req", 32'(nvm_req), 32'd0);

    // Key 2'b10, good parity, zero-wait NVM
    run_load(enc(2'b10, 1'b0), 1'b0, 2'b10, 1'b1, "load10");

    // Reload from DONE with a start pulse during the load that must be ignored
    run_load(enc(2'b11, 1'b0), 1'b1, 2'b11, 1'b1, "reload11");

`ifdef C432_KEY_PARITY_EN
    // Bits 0,1 with parity 0: parity fails
    run_load(3'b010, 1'b0, 2'b10, 1'b0, "badpar");
`endif

    // Timeout on the second bit
    start = 1'b1;
    step();
    start = 1'b0;
    nvm_ack = 1'b1;
    nvm_bit = 1'b1;
    step();
    nvm_ack = 1'b0;
    step();
    check("tmo req2", 32'(nvm_req), 32'd1);
    for (int i = 0; i < 15; i++) step();
    check("tmo still_req", 32'(nvm_req), 32'd1);
    check("tmo no_err_yet", 32'(key_err), 32'd0);
    step();
    check("tmo err", 32'(key_err), 32'd1);
    check("tmo req_drop", 32'(nvm_req), 32'd0);
    check("tmo busy", 32'(busy), 32'd0);
    check("tmo key", 32'(key), 32'd0);
    check("tmo valid", 32'(key_valid), 32'd0);

    // Reset while in GAP after the first bit, then a clean reload of 2'b01
    start = 1'b1;
    step();
    start = 1'b0;
    nvm_ack = 1'b1;
    nvm_bit = 1'b1;
    step();
    nvm_ack = 1'b0;
    check("mid gap", 32'(nvm_req), 32'd0);
    rst_n = 1'b0;
    step();
    check("mid rst req", 32'(nvm_req), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst err", 32'(key_err), 32'd0);
    check("mid rst valid", 32'(key_valid), 32'd0);
    check("mid rst key", 32'(key), 32'd0);
    rst_n = 1'b1;
    step();
    check("mid idle req", 32'(nvm_req), 32'd0);
    run_load(enc(2'b01, 1'b0), 1'b0, 2'b01, 1'b1, "load01");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
